// File: rtl/dma_read_streamer.sv
// Streams num_lines cache lines from host memory into a downstream fifobram.
// Optional issue-stall counter is built when DMA_READ_STALL_COUNT_EN is defined.
module dma_read_streamer #(
  parameter int LOG2_DEPTH      = 9,
  parameter int MAX_OUTSTANDING = 496
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [41:0]           addr,
  input  logic [31:0]           num_lines,
  output logic                  idle,
  output logic                  active,
  output logic                  done,
  output logic                  tx_re,
  output logic [41:0]           tx_raddr,
  output logic [1:0]            tx_rlength,
  input  logic                  rx_rvalid,
  input  logic [511:0]          rx_rdata,
  input  logic                  rx_almostfull,
  output logic                  out_we,
  output logic [LOG2_DEPTH-1:0] out_waddr,
  output logic [511:0]          out_wdata,
  input  logic                  out_almostfull,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT, S_DONE} state_t;

  state_t      state_reg;
  logic [41:0] base_reg;
  logic [31:0] lines_reg;
  logic [31:0] issued_reg;
  logic [31:0] written_reg;
  logic [31:0] outstanding_reg;

  logic start_ok;
  logic issue;
  logic accept;
  logic last_issue;
  logic last_write;

  always_comb begin
    start_ok   = start && (state_reg == S_IDLE || state_reg == S_DONE);
    issue      = (state_reg == S_REQUEST) &&
                 (outstanding_reg < 32'(MAX_OUTSTANDING)) &&
                 !rx_almostfull && !out_almostfull;
    // Responses outside a running job belong to an abandoned job and are dropped.
    accept     = rx_rvalid && (state_reg == S_REQUEST || state_reg == S_WAIT);
    last_issue = issue && (issued_reg == lines_reg - 32'd1);
    last_write = accept && (written_reg == lines_reg - 32'd1);
  end

  assign idle       = (state_reg == S_IDLE);
  assign active     = (state_reg == S_REQUEST) || (state_reg == S_WAIT);
  assign done       = (state_reg == S_DONE);
  assign tx_rlength = 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      base_reg        <= '0;
      lines_reg       <= '0;
      issued_reg      <= '0;
      written_reg     <= '0;
      outstanding_reg <= '0;
      tx_re           <= 1'b0;
      tx_raddr        <= '0;
      out_we          <= 1'b0;
      out_waddr       <= '0;
      out_wdata       <= '0;
    end else begin
      tx_re  <= issue;
      out_we <= accept;

      if (issue) begin
        tx_raddr   <= base_reg + 42'(issued_reg);
        issued_reg <= issued_reg + 32'd1;
      end

      if (accept) begin
        out_wdata   <= rx_rdata;
        out_waddr   <= written_reg[LOG2_DEPTH-1:0];
        written_reg <= written_reg + 32'd1;
      end

      case ({issue, accept})
        2'b10:   outstanding_reg <= outstanding_reg + 32'd1;
        2'b01:   outstanding_reg <= outstanding_reg - 32'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase

      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            base_reg        <= addr;
            lines_reg       <= num_lines;
            issued_reg      <= '0;
            written_reg     <= '0;
            outstanding_reg <= '0;
            out_waddr       <= '0;
            state_reg       <= (num_lines == 32'd0) ? S_DONE : S_REQUEST;
          end
        end
        S_REQUEST: if (last_issue) state_reg <= S_WAIT;
        S_WAIT:    if (last_write) state_reg <= S_DONE;
        default:   state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef DMA_READ_STALL_COUNT_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (start_ok) begin
      stall_reg <= '0;
    end else if (state_reg == S_REQUEST && !issue && stall_reg != 32'hFFFF_FFFF) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dma_read_streamer.sv
// Self-checking bench for dma_read_streamer: directed vector table, corner
// sequences and randomized jobs against a transaction-level reference model.
module tb_dma_read_streamer;
  localparam int L    = 2;
  localparam int MAXO = 4;
`ifdef DMA_READ_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, rx_rvalid, rx_almostfull, out_almostfull;
  logic [41:0]  addr;
  logic [31:0]  num_lines;
  logic         idle, active, done, tx_re, out_we;
  logic [41:0]  tx_raddr;
  logic [1:0]   tx_rlength;
  logic [511:0] rx_rdata, out_wdata;
  logic [L-1:0] out_waddr;
  logic [31:0]  stall_cycles;

  always #5 clk = ~clk;

  dma_read_streamer #(.LOG2_DEPTH(L), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .num_lines(num_lines),
    .idle(idle), .active(active), .done(done), .tx_re(tx_re), .tx_raddr(tx_raddr),
    .tx_rlength(tx_rlength), .rx_rvalid(rx_rvalid), .rx_rdata(rx_rdata),
    .rx_almostfull(rx_almostfull), .out_we(out_we), .out_waddr(out_waddr),
    .out_wdata(out_wdata), .out_almostfull(out_almostfull), .stall_cycles(stall_cycles)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_req_seen = 0;
  int host_lat   = 2;
  int pending[$];
  int wlog[$];

  // Reference model: a job is idle, running or done; a running job owns
  // counts of lines requested, lines written and requests in flight.
  int           m_phase = 0;
  logic [41:0]  m_base;
  logic [31:0]  m_n, m_issued, m_written, m_out, m_stall;
  logic         e_re, e_we;
  logic [41:0]  e_raddr;
  logic [L-1:0] e_waddr;
  logic [511:0] e_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic [41:0] a,
                            input logic [31:0] n, input logic rv, input logic [511:0] d,
                            input logic raf, input logic oaf);
    logic running, want, can, acc;
    if (rst) begin
      m_phase = 0; m_base = '0; m_n = '0; m_issued = '0; m_written = '0; m_out = '0;
      m_stall = '0; e_re = 1'b0; e_we = 1'b0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
      return;
    end
    running = (m_phase == 1);
    want    = running && (m_issued < m_n);
    can     = want && (m_out < 32'(MAXO)) && !raf && !oaf;
    acc     = running && rv;
    if (want && !can && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    e_re = can;
    if (can) begin
      e_raddr  = m_base + 42'(m_issued);
      m_issued = m_issued + 1;
      m_out    = m_out + 1;
    end
    e_we = acc;
    if (acc) begin
      e_wdata   = d;
      e_waddr   = m_written[L-1:0];
      m_written = m_written + 1;
      m_out     = m_out - 1;
      if (m_written == m_n) m_phase = 2;
    end
    if (!running && st) begin
      m_base = a; m_n = n; m_issued = '0; m_written = '0; m_out = '0; m_stall = '0;
      e_waddr = '0;
      m_phase = (n == 32'd0) ? 2 : 1;
    end
  endtask

  task automatic tick(input logic rst_i, input logic st_i, input logic [41:0] a_i,
                      input logic [31:0] n_i, input logic rv_i, input logic [511:0] d_i,
                      input logic raf_i, input logic oaf_i);
    reset = rst_i; start = st_i; addr = a_i; num_lines = n_i;
    rx_rvalid = rv_i; rx_rdata = d_i; rx_almostfull = raf_i; out_almostfull = oaf_i;
    model_step(rst_i, st_i, a_i, n_i, rv_i, d_i, raf_i, oaf_i);
    @(negedge clk);
    cyc++;
    chk("idle", 64'(idle), 64'(m_phase == 0));
    chk("active", 64'(active), 64'(m_phase == 1));
    chk("done", 64'(done), 64'(m_phase == 2));
    chk("tx_re", 64'(tx_re), 64'(e_re));
    if (e_re) chk("tx_raddr", 64'(tx_raddr), 64'(e_raddr));
    chk("tx_rlength", 64'(tx_rlength), 64'd0);
    chk("out_we", 64'(out_we), 64'(e_we));
    if (e_we) begin
      chk("out_waddr", 64'(out_waddr), 64'(e_waddr));
      chkw("out_wdata", out_wdata, e_wdata);
    end
    chk("stall_cycles", 64'(stall_cycles), STALL_EN ? 64'(m_stall) : 64'd0);
    if (tx_re) begin
      pending.push_back(cyc + host_lat);
      n_req_seen++;
    end
    if (out_we) wlog.push_back(int'(out_waddr));
  endtask

  task automatic host_tick(input logic raf_i, input logic oaf_i, input logic allow,
                           input logic st_i, input logic [41:0] a_i, input logic [31:0] n_i);
    logic         rv_l;
    logic [511:0] d_l;
    for (int k = 0; k < 16; k++) d_l[k*32 +: 32] = $urandom;
    rv_l = 1'b0;
    if (allow && pending.size() > 0 && pending[0] <= cyc) begin
      rv_l = 1'b1;
      void'(pending.pop_front());
    end
    tick(1'b0, st_i, a_i, n_i, rv_l, d_l, raf_i, oaf_i);
  endtask

  task automatic drain(input int budget, input logic rnd);
    int          k;
    logic [41:0] a_r;
    logic [31:0] n_r;
    k = 0;
    while ((m_phase == 1 || pending.size() > 0) && k < budget) begin
      if (rnd) begin
        a_r = {10'($urandom), $urandom};
        n_r = 32'($urandom_range(1, 20));
        host_tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, a_r, n_r);
      end else begin
        host_tick(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      end
      k++;
    end
    chk("drain_in_budget", 64'(k < budget), 64'd1);
  endtask

  typedef struct {
    logic        st;
    logic [41:0] a;
    logic [31:0] n;
    logic        rv;
    logic        e_idle, e_act, e_done, e_re;
    logic [41:0] e_raddr;
    logic        e_we;
    logic [1:0]  e_waddr;
  } vec_t;

  function automatic vec_t v(input logic st, input logic [41:0] a, input logic [31:0] n,
                             input logic rv, input logic ei, input logic ea, input logic ed,
                             input logic er, input logic [41:0] era, input logic ew,
                             input logic [1:0] ewa);
    vec_t r;
    r.st = st; r.a = a; r.n = n; r.rv = rv; r.e_idle = ei; r.e_act = ea; r.e_done = ed;
    r.e_re = er; r.e_raddr = era; r.e_we = ew; r.e_waddr = ewa;
    return r;
  endfunction

  initial begin
    vec_t         tbl[15];
    logic [511:0] d;
    logic [41:0]  a_r;
    logic [31:0]  n_r;
    int           base_seen;
    int           exp_seq[6] = '{0, 1, 2, 3, 0, 1};

    // zero-line job, then addr=0x100 x4 with a start ignored mid-job, then a wrapping job
    tbl[0]  = v(1, 42'h0AA, 0, 0, 0, 0, 1, 0, 42'h0, 0, 2'd0);
    tbl[1]  = v(0, 42'h0, 0, 0, 0, 0, 1, 0, 42'h0, 0, 2'd0);
    tbl[2]  = v(1, 42'h100, 4, 0, 0, 1, 0, 0, 42'h0, 0, 2'd0);
    tbl[3]  = v(1, 42'h200, 7, 0, 0, 1, 0, 1, 42'h100, 0, 2'd0);
    tbl[4]  = v(0, 42'h300, 9, 0, 0, 1, 0, 1, 42'h101, 0, 2'd0);
    tbl[5]  = v(0, 42'h0, 0, 1, 0, 1, 0, 1, 42'h102, 1, 2'd0);
    tbl[6]  = v(0, 42'h0, 0, 1, 0, 1, 0, 1, 42'h103, 1, 2'd1);
    tbl[7]  = v(0, 42'h0, 0, 1, 0, 1, 0, 0, 42'h0, 1, 2'd2);
    tbl[8]  = v(0, 42'h0, 0, 1, 0, 0, 1, 0, 42'h0, 1, 2'd3);
    tbl[9]  = v(0, 42'h0, 0, 0, 0, 0, 1, 0, 42'h0, 0, 2'd0);
    tbl[10] = v(1, 42'h3FF_FFFF_FFFF, 2, 0, 0, 1, 0, 0, 42'h0, 0, 2'd0);
    tbl[11] = v(0, 42'h0, 0, 0, 0, 1, 0, 1, 42'h3FF_FFFF_FFFF, 0, 2'd0);
    tbl[12] = v(0, 42'h0, 0, 0, 0, 1, 0, 1, 42'h0, 0, 2'd0);
    tbl[13] = v(0, 42'h0, 0, 1, 0, 1, 0, 0, 42'h0, 1, 2'd0);
    tbl[14] = v(0, 42'h0, 0, 1, 0, 0, 1, 0, 42'h0, 1, 2'd1);

    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_flags", 64'({active, done, tx_re, out_we}), 64'd0);
    chk("rst_tx_raddr", 64'(tx_raddr), 64'd0);
    chk("rst_out_waddr", 64'(out_waddr), 64'd0);
    chkw("rst_out_wdata", out_wdata, '0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);

    for (int i = 0; i < 15; i++) begin
      d = {16{32'hD000_0000 + 32'(i)}};
      tick(1'b0, tbl[i].st, tbl[i].a, tbl[i].n, tbl[i].rv, d, 1'b0, 1'b0);
      chk($sformatf("vec%0d_flags", i), 64'({idle, active, done}),
          64'({tbl[i].e_idle, tbl[i].e_act, tbl[i].e_done}));
      chk($sformatf("vec%0d_tx_re", i), 64'(tx_re), 64'(tbl[i].e_re));
      if (tbl[i].e_re) chk($sformatf("vec%0d_tx_raddr", i), 64'(tx_raddr), 64'(tbl[i].e_raddr));
      chk($sformatf("vec%0d_out_we", i), 64'(out_we), 64'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_out_waddr", i), 64'(out_waddr), 64'(tbl[i].e_waddr));
        chkw($sformatf("vec%0d_out_wdata", i), out_wdata, d);
      end
    end
    $display("vector table: %0d records applied", 15);

    // Outstanding limit: 4 requests, then one more only after a response.
    pending.delete();
    base_seen = n_req_seen;
    tick(1'b0, 1'b1, 42'h1234, 32'd10, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) host_tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("max_out_first_burst", 64'(n_req_seen - base_seen), 64'd4);
    host_tick(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) host_tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("max_out_after_rsp", 64'(n_req_seen - base_seen), 64'd5);
    drain(300, 1'b0);
    $display("max outstanding job: %0d requests total", n_req_seen - base_seen);

    // Write address wrap with a 4-entry buffer.
    wlog.delete();
    tick(1'b0, 1'b1, 42'h40, 32'd6, 1'b0, '0, 1'b0, 1'b0);
    drain(200, 1'b0);
    chk("wrap_len", 64'(wlog.size()), 64'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk($sformatf("wrap_waddr%0d", i), 64'(wlog[i]), 64'(exp_seq[i]));
    $display("waddr wrap job: %0d writes", wlog.size());

    // Downstream almost-full held for 5 request cycles.
    base_seen = n_req_seen;
    tick(1'b0, 1'b1, 42'h800, 32'd3, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) host_tick(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    chk("stall_no_tx_re", 64'(n_req_seen - base_seen), 64'd0);
    drain(200, 1'b0);
    chk("stall_total", 64'(stall_cycles), STALL_EN ? 64'd5 : 64'd0);
    chk("stall_job_done", 64'(done), 64'd1);
    $display("stall job: stall_cycles=%0d", stall_cycles);

    // Reset after 2 of 8 requests; the late responses must be dropped.
    base_seen = n_req_seen;
    tick(1'b0, 1'b1, 42'h900, 32'd8, 1'b0, '0, 1'b0, 1'b0);
    host_tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    host_tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("abort_two_issued", 64'(n_req_seen - base_seen), 64'd2);
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    pending.delete();
    wlog.delete();
    tick(1'b0, 1'b0, '0, '0, 1'b1, {16{32'hBAD0_0001}}, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, '0, 1'b1, {16{32'hBAD0_0002}}, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("abort_no_writes", 64'(wlog.size()), 64'd0);
    chk("abort_idle", 64'({idle, active, done}), 64'b100);
    chk("abort_tx", 64'({tx_re, tx_raddr}), 64'd0);
    chk("abort_out", 64'({out_we, out_waddr}), 64'd0);
    chkw("abort_wdata", out_wdata, '0);
    chk("abort_stall", 64'(stall_cycles), 64'd0);
    $display("reset-abort job: idle=%0b writes=%0d", idle, wlog.size());

    // Randomized jobs with backpressure, variable host latency and stray starts.
    for (int j = 0; j < 30; j++) begin
      host_lat = $urandom_range(1, 5);
      a_r = ($urandom_range(0, 3) == 0) ? (42'h3FF_FFFF_FFF0 + 42'($urandom_range(0, 15)))
                                        : {10'($urandom), $urandom};
      n_r = 32'($urandom_range(0, 12));
      base_seen = n_req_seen;
      tick(1'b0, 1'b1, a_r, n_r, 1'b0, '0, 1'b0, 1'b0);
      drain(2000, 1'b1);
      chk($sformatf("rand%0d_req_count", j), 64'(n_req_seen - base_seen), 64'(n_r));
      $display("random job %0d: addr=%0h lines=%0d latency=%0d", j, a_r, n_r, host_lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
